// File: rtl/mux_pkg.sv
// Shared definitions for the mux_scan block: mode encodings and scan FSM states.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL     = 1'b0,
    ST_SCAN_DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin scan pointer for mux_scan: dwells at most DWELL cycles per channel
// and moves on early once the pointed channel has transferred a word.
module mux_scan_ptr
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             xfer,
  output logic [SEL_W-1:0] ptr
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;

  // NOTE: every next-state variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    unique case (state_q)
      ST_MANUAL: begin
        ptr_d   = '0;
        dwell_d = '0;
        if (mode == MODE_SCAN) state_d = ST_SCAN_DWELL;
      end
      ST_SCAN_DWELL: begin
        if (mode == MODE_MANUAL) begin
          state_d = ST_MANUAL;
          ptr_d   = '0;
          dwell_d = '0;
        end else if (xfer || (32'(dwell_q) == DWELL - 1)) begin
          ptr_d   = (32'(ptr_q) == CHANNELS - 1) ? '0 : ptr_q + SEL_W'(1);
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      ptr_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 word mux with valid/ready on every channel, manual or round-robin scan select.
// Optional transfer/stall counters are built when MUX_SCAN_COUNT_EN is defined.
module mux_scan
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
`ifdef MUX_SCAN_COUNT_EN
  ,
  output logic [15:0]               xfer_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  logic [SEL_W-1:0] ptr, act;
  logic             act_ok, can_load, xfer;
  logic [WIDTH-1:0] act_word;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  mux_scan_ptr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .xfer (xfer),
    .ptr  (ptr)
  );

  // Decode the active channel; an out-of-range manual select matches no channel at all.
  always_comb begin
    act      = (mode == MODE_SCAN) ? ptr : sel_in;
    act_ok   = (mode == MODE_SCAN) || (32'(sel_in) < CHANNELS);
    can_load = !out_valid_q || out_ready;
    in_ready = '0;
    xfer     = 1'b0;
    act_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (act_ok && (32'(act) == k)) begin
        in_ready[k] = can_load && !rst;
        xfer        = can_load && !rst && in_valid[k];
        act_word    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = act_word;
      out_ch_d    = act;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    sel_err_d = sel_err_q || ((mode == MODE_MANUAL) && !act_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_SCAN_COUNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Transfer count wraps; stall count saturates so long stalls stay visible.
  always_comb begin
    xfer_cnt_d  = xfer ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
Parametrised, registered N:1 word multiplexer with a valid/ready handshake on every input channel and on the output. It is the generalised successor of the 2:1 single-bit select mux. Two modes:
- Manual: the channel is chosen by an external select.
- Scan: an internal round-robin pointer visits each channel for a bounded dwell time.
Sits between the channel sources and a single downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- DWELL, 4, maximum cycles the scan pointer stays on one channel (>=1).
- SEL_W, $clog2(CHANNELS), select/pointer width. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = manual, 1 = scan.
- sel_in  input  SEL_W  manual channel select.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel k occupies [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit is high.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SEL_W  channel index of out_data.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- sel_err  output  1  sticky flag: manual sel_in >= CHANNELS was seen.

Behaviour:
- Reset: every output is 0 (out_data, out_ch, out_valid, in_ready, sel_err); scan pointer = 0; dwell counter = 0.
- Active channel:
  - Manual mode: sel_in.
  - Scan mode: the pointer.
- Output register:
  - can_load = !out_valid || out_ready.
  - in_ready[act] = can_load and act is in range; all other in_ready bits are 0 (combinational).
- Transfer: when in_valid[act] && in_ready[act], on the next edge out_data <= word of channel act, out_ch <= act, out_valid <= 1. Latency is 1 cycle.
- Draining: out_valid && out_ready with no new load clears out_valid. Simultaneous drain and load keeps out_valid = 1 with the new word, so full throughput is 1 word/cycle.
- Backpressure: while out_valid && !out_ready, out_data and out_ch hold; in_ready is all 0.
- Out-of-range select: manual sel_in >= CHANNELS selects nothing, gives in_ready = 0 and sets sel_err. sel_err clears only on rst.
- Scan FSM states:
  - MANUAL: mode = 0. Pointer and dwell counter are held at 0.
  - SCAN_DWELL: mode = 1. The dwell counter increments each cycle. The pointer advances (wrapping CHANNELS-1 -> 0) and the dwell counter zeroes when either:
    - a transfer occurs from the pointed channel, or
    - the dwell counter reaches DWELL-1.
  - Transitions:
    - MANUAL -> SCAN_DWELL when mode = 1; the pointer starts at 0.
    - SCAN_DWELL -> MANUAL when mode = 0; the pointer and dwell counter are cleared on that edge.
- Mode change with out_valid = 1: the held word is unaffected and still waits for out_ready.
- rst mid-transfer: the pending output word is discarded (out_valid = 0) and the FSM returns to MANUAL.
- Scan mode never produces sel_err.

Optional Feature:
MUX_SCAN_COUNT_EN
- Defined:
  - Adds output port xfer_cnt [15:0], a count of accepted input transfers that wraps at 16'hFFFF -> 0.
  - Adds output port stall_cnt [15:0], a count of cycles with out_valid && !out_ready that saturates at 16'hFFFF.
  - Both counters reset to 0 on rst.
- Undefined: neither port exists, and no counter logic is present.

Decomposition:
- Shared package/header (mux_pkg): MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1, and the FSM state encodings ST_MANUAL and ST_SCAN_DWELL.
- One sub-module, mux_scan_ptr, holds the FSM, pointer and dwell counter.
  - Inputs: clk, rst, mode, xfer.
  - Output: ptr.
  - Parameters: CHANNELS, DWELL.
- The top level holds the select decode, output register and handshake.

Test Plan:
- Manual pass-through: CHANNELS = 4, mode = 0, sel_in = 2, in_data ch2 = 8'hA5, in_valid = 4'b0100, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 8'hA5, out_ch = 2, out_valid = 1.
- Backpressure: out_valid = 1 and out_ready = 0 for 3 cycles while ch2 changes to 8'h3C -> out_data stays 8'hA5, in_ready = 0. Raise out_ready -> 8'h3C appears the following cycle.
- Scan with idle channels: mode = 1, DWELL = 4, in_valid = 0 -> the pointer visits 0,1,2,3,0 at 4-cycle intervals. Then in_valid = 4'b1111 -> out_ch sequence is 0,1,2,3,0 on consecutive cycles.
- Out-of-range select: CHANNELS = 3, mode = 0, sel_in = 3 -> in_ready = 0, sel_err = 1 and remains 1 after sel_in = 0, until rst.
- Reset mid-operation: out_valid = 1, scan pointer = 2, then rst pulsed 1 cycle -> out_valid = 0, out_data = 0, sel_err = 0. Then mode = 1 -> scan restarts at channel 0.
- Counters (MUX_SCAN_COUNT_EN defined): 5 transfers and 7 stall cycles -> xfer_cnt = 5, stall_cnt = 7.
